// File: rtl/wb_stage_n.sv
// ---------------------------------------------------------------------------
// WbStageN (module wb_stage_n) - write-back pipeline stage
//
// Purpose:
//   MEM/WB pipeline register with a four-way write-back source select
//   (ALU result, memory data, PC+2, immediate). Loads that have not yet
//   received their data are parked in WAIT_MEM until mem_done. The stage
//   also supports flush, a sticky halt and a saturating stall counter.
//   It drives the register-file write port in decode.
//
// Optional feature:
//   WB_FWD_EN - when defined, fwd_* mirror the register-file write this
//   cycle for the decode/execute bypass. When undefined, fwd_* are tied to
//   zero. The port list is identical in both builds.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid       memory stage presents an instruction
//   in_ready       stage can accept this cycle (IDLE only)
//   alu_out        execute result
//   pc_plus2       PC+2, used for link
//   imm            immediate, used for load-immediate
//   wb_sel         0 ALU, 1 MEM, 2 PC+2, 3 IMM
//   reg_wr_in      instruction writes a register
//   dst_in         destination register
//   is_load        instruction needs mem_data
//   halt_in        instruction is HALT
//   flush          kill the pending/incoming instruction
//   mem_done       mem_data valid this cycle
//   mem_data       memory read data
//   reg_wr_en      one-cycle register-file write strobe
//   reg_wr_addr    write address
//   reg_data       write data
//   halted         sticky halt indication
//   stall_cnt      cycles spent in WAIT_MEM, saturating
//   fwd_valid      bypass valid
//   fwd_addr       bypass register
//   fwd_data       bypass value
// ---------------------------------------------------------------------------
module wb_stage_n #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] pc_plus2,
  input  logic [DATA_W-1:0] imm,
  input  logic [1:0]        wb_sel,
  input  logic              reg_wr_in,
  input  logic [REG_AW-1:0] dst_in,
  input  logic              is_load,
  input  logic              halt_in,
  input  logic              flush,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_data,
  output logic              reg_wr_en,
  output logic [REG_AW-1:0] reg_wr_addr,
  output logic [DATA_W-1:0] reg_data,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    HALT     = 2'd2
  } stateT;

  stateT state;
  stateT nextState;

  // Fields of a load that is waiting for its memory data
  logic [1:0]        selQ;
  logic              wrQ;
  logic [REG_AW-1:0] dstQ;
  logic [DATA_W-1:0] aluQ;
  logic [DATA_W-1:0] pcQ;
  logic [DATA_W-1:0] immQ;

  logic              accept;
  logic              doCommit;
  logic              commitWr;
  logic [REG_AW-1:0] commitAddr;
  logic [DATA_W-1:0] commitData;
  logic              doLatch;
  logic              setHalt;

  // Full-width source mux; memory data is always the live bus value
  function automatic logic [DATA_W-1:0] selectSource(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] aluV,
    input logic [DATA_W-1:0] memV,
    input logic [DATA_W-1:0] pcV,
    input logic [DATA_W-1:0] immV
  );
    case (sel)
      2'd0:    return aluV;
      2'd1:    return memV;
      2'd2:    return pcV;
      default: return immV;
    endcase
  endfunction

  // Ready depends on state alone so upstream never sees a loop through in_valid
  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  // Next-state and commit decisions. Flush has top priority in every state
  // that can hold an instruction, so a flush arriving with mem_done still
  // discards the load. A load whose data is already present on the accept
  // cycle commits straight away instead of visiting WAIT_MEM.
  always_comb begin
    nextState  = state;
    doCommit   = 1'b0;
    commitWr   = 1'b0;
    commitAddr = dstQ;
    commitData = selectSource(selQ, aluQ, mem_data, pcQ, immQ);
    doLatch    = 1'b0;
    setHalt    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (flush) begin
            nextState = IDLE;
          end else if (halt_in) begin
            nextState = HALT;
            setHalt   = 1'b1;
          end else if (is_load && !mem_done) begin
            nextState = WAIT_MEM;
            doLatch   = 1'b1;
          end else begin
            doCommit   = 1'b1;
            commitWr   = reg_wr_in;
            commitAddr = dst_in;
            commitData = selectSource(wb_sel, alu_out, mem_data, pc_plus2, imm);
          end
        end
      end
      WAIT_MEM: begin
        if (flush) begin
          nextState = IDLE;
        end else if (mem_done) begin
          nextState = IDLE;
          doCommit  = 1'b1;
          commitWr  = wrQ;
        end
      end
      HALT: begin
        nextState = HALT;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // State register and registered outputs. The write strobe is rewritten
  // every cycle so it can only ever be a single-cycle pulse; address and
  // data only change on a commit. The stall counter counts every cycle
  // spent in WAIT_MEM and sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_data    <= '0;
      halted      <= 1'b0;
      stall_cnt   <= '0;
      selQ        <= '0;
      wrQ         <= 1'b0;
      dstQ        <= '0;
      aluQ        <= '0;
      pcQ         <= '0;
      immQ        <= '0;
    end else begin
      state     <= nextState;
      reg_wr_en <= doCommit && commitWr;
      if (doCommit) begin
        reg_wr_addr <= commitAddr;
        reg_data    <= commitData;
      end
      if (setHalt) begin
        halted <= 1'b1;
      end
      if ((state == WAIT_MEM) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (doLatch) begin
        selQ <= wb_sel;
        wrQ  <= reg_wr_in;
        dstQ <= dst_in;
        aluQ <= alu_out;
        pcQ  <= pc_plus2;
        immQ <= imm;
      end
    end
  end

`ifdef WB_FWD_EN
  // Bypass mirrors the write port; suppressed while a load is still waiting
  assign fwd_valid = reg_wr_en && (state != WAIT_MEM);
  assign fwd_addr  = reg_wr_addr;
  assign fwd_data  = reg_data;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage_n.sv
// ---------------------------------------------------------------------------
// TbWbStageN (module tb_wb_stage_n) - self-checking bench for wb_stage_n
//
// Directed cases followed by randomized traffic. A behavioural model on the
// rising edge pushes expected register writes into a queue; a monitor on the
// falling edge pops and compares whenever a write is due, and also compares
// ready/halt/stall status against the model every cycle.
// ---------------------------------------------------------------------------
module tb_wb_stage_n;

  localparam int DATA_W  = 16;
  localparam int REG_AW  = 3;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] pc_plus2;
  logic [DATA_W-1:0] imm;
  logic [1:0]        wb_sel;
  logic              reg_wr_in;
  logic [REG_AW-1:0] dst_in;
  logic              is_load;
  logic              halt_in;
  logic              flush;
  logic              mem_done;
  logic [DATA_W-1:0] mem_data;
  logic              reg_wr_en;
  logic [REG_AW-1:0] reg_wr_addr;
  logic [DATA_W-1:0] reg_data;
  logic              halted;
  logic [CNT_W-1:0]  stall_cnt;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wrT;

  wrT expQ[$];

  // Reference model state: is a load outstanding, is the core halted, and
  // how many cycles have been spent waiting on memory
  bit                mBusy   = 1'b0;
  bit                mHalted = 1'b0;
  int                mStall  = 0;
  logic [1:0]        pSel;
  logic              pWr;
  logic [REG_AW-1:0] pDst;
  logic [DATA_W-1:0] pAlu;
  logic [DATA_W-1:0] pPc;
  logic [DATA_W-1:0] pImm;

  wb_stage_n #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .pc_plus2(pc_plus2), .imm(imm), .wb_sel(wb_sel),
    .reg_wr_in(reg_wr_in), .dst_in(dst_in), .is_load(is_load),
    .halt_in(halt_in), .flush(flush), .mem_done(mem_done), .mem_data(mem_data),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_data(reg_data),
    .halted(halted), .stall_cnt(stall_cnt),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Single comparison point shared by directed checks and the monitor
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
               name, actual, expected, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] pickSource(
    input logic [1:0] sel, input logic [DATA_W-1:0] a, m, p, i);
    case (sel)
      2'd0:    return a;
      2'd1:    return m;
      2'd2:    return p;
      default: return i;
    endcase
  endfunction

  // Reference model: decides on each rising edge what the stage does with
  // the inputs currently applied, and queues the write that must follow
  always @(posedge clk) begin
    if (rst) begin
      mBusy   <= 1'b0;
      mHalted <= 1'b0;
      mStall  <= 0;
    end else if (mHalted) begin
      mHalted <= 1'b1;
    end else if (mBusy) begin
      if (mStall < CNT_MAX) mStall <= mStall + 1;
      if (flush) begin
        mBusy <= 1'b0;
      end else if (mem_done) begin
        mBusy <= 1'b0;
        if (pWr) expQ.push_back('{pDst, pickSource(pSel, pAlu, mem_data, pPc, pImm)});
      end
    end else if (in_valid) begin
      if (flush) begin
        mBusy <= 1'b0;
      end else if (halt_in) begin
        mHalted <= 1'b1;
      end else if (is_load && !mem_done) begin
        mBusy <= 1'b1;
        pSel  <= wb_sel;
        pWr   <= reg_wr_in;
        pDst  <= dst_in;
        pAlu  <= alu_out;
        pPc   <= pc_plus2;
        pImm  <= imm;
      end else if (reg_wr_in) begin
        expQ.push_back('{dst_in, pickSource(wb_sel, alu_out, mem_data, pc_plus2, imm)});
      end
    end
  end

  // Monitor: on the falling edge, any queued write must be on the port now,
  // and no write may appear without one queued
  always @(negedge clk) begin
    wrT e;
    bit want;
    want = (expQ.size() > 0);
    checkOutput("wr_en", 32'(reg_wr_en), 32'(want));
    if (want) begin
      e = expQ.pop_front();
      if (reg_wr_en) begin
        checkOutput("wr_addr", 32'(reg_wr_addr), 32'(e.addr));
        checkOutput("wr_data", 32'(reg_data), 32'(e.data));
      end
    end
    checkOutput("in_ready", 32'(in_ready), 32'(!(mBusy || mHalted)));
    checkOutput("halted", 32'(halted), 32'(mHalted));
    checkOutput("stall_cnt", 32'(stall_cnt), 32'(mStall));
`ifdef WB_FWD_EN
    checkOutput("fwd_valid", 32'(fwd_valid), 32'(want));
    if (want && fwd_valid) begin
      checkOutput("fwd_addr", 32'(fwd_addr), 32'(e.addr));
      checkOutput("fwd_data", 32'(fwd_data), 32'(e.data));
    end
`else
    checkOutput("fwd_valid", 32'(fwd_valid), 32'd0);
    checkOutput("fwd_addr", 32'(fwd_addr), 32'd0);
    checkOutput("fwd_data", 32'(fwd_data), 32'd0);
`endif
  end

  // Apply one cycle of inputs, then return just after the rising edge
  task automatic applyStimulus(
    input logic v, input logic [1:0] sel,
    input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] pc,
    input logic [DATA_W-1:0] im, input logic wr, input logic [REG_AW-1:0] dst,
    input logic ld, input logic hlt, input logic fl, input logic done,
    input logic [DATA_W-1:0] md);
    in_valid  = v;
    wb_sel    = sel;
    alu_out   = alu;
    pc_plus2  = pc;
    imm       = im;
    reg_wr_in = wr;
    dst_in    = dst;
    is_load   = ld;
    halt_in   = hlt;
    flush     = fl;
    mem_done  = done;
    mem_data  = md;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    idleCycles(1);
    rst = 1'b0;
  endtask

  // Directed cases first, then random traffic, then the summary
  initial begin
    doReset();
    checkOutput("rst_wr_en", 32'(reg_wr_en), 32'd0);
    checkOutput("rst_addr", 32'(reg_wr_addr), 32'd0);
    checkOutput("rst_data", 32'(reg_data), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_stall", 32'(stall_cnt), 32'd0);
    checkOutput("rst_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_fwd", 32'(fwd_valid), 32'd0);

    // ALU write, then strobe must drop
    applyStimulus(1, 0, 16'h1234, 16'h0, 16'h0, 1, 3'd5, 0, 0, 0, 0, 16'h0);
    checkOutput("alu_wr_en", 32'(reg_wr_en), 32'd1);
    checkOutput("alu_addr", 32'(reg_wr_addr), 32'd5);
    checkOutput("alu_data", 32'(reg_data), 32'h1234);
    idleCycles(1);
    checkOutput("alu_wr_drop", 32'(reg_wr_en), 32'd0);

    // Link and load-immediate
    applyStimulus(1, 2, 16'h1111, 16'h0042, 16'h2222, 1, 3'd7, 0, 0, 0, 0, 16'h3333);
    checkOutput("link_addr", 32'(reg_wr_addr), 32'd7);
    checkOutput("link_data", 32'(reg_data), 32'h0042);
    applyStimulus(1, 3, 16'h1111, 16'h0042, 16'hFFEE, 1, 3'd1, 0, 0, 0, 0, 16'h3333);
    checkOutput("imm_data", 32'(reg_data), 32'hFFEE);

    // MEM select on a non-load samples mem_data on the accept cycle
    applyStimulus(1, 1, 16'h1111, 16'h0, 16'h0, 1, 3'd4, 0, 0, 0, 0, 16'h5A5A);
    checkOutput("memsel_data", 32'(reg_data), 32'h5A5A);

    // Bypass mirrors an ALU write to R3
    applyStimulus(1, 0, 16'h00AA, 16'h0, 16'h0, 1, 3'd3, 0, 0, 0, 0, 16'h0);
`ifdef WB_FWD_EN
    checkOutput("fwd_valid_wr", 32'(fwd_valid), 32'd1);
    checkOutput("fwd_addr_wr", 32'(fwd_addr), 32'd3);
    checkOutput("fwd_data_wr", 32'(fwd_data), 32'h00AA);
`else
    checkOutput("fwd_valid_off", 32'(fwd_valid), 32'd0);
    checkOutput("fwd_data_off", 32'(fwd_data), 32'd0);
`endif
    idleCycles(1);

    // Multi-cycle load: three cycles waiting, commit on mem_done
    applyStimulus(1, 1, 16'h1111, 16'h2222, 16'h3333, 1, 3'd2, 1, 0, 0, 0, 16'h0);
    checkOutput("ld_ready0", 32'(in_ready), 32'd0);
    idleCycles(1);
    checkOutput("ld_ready1", 32'(in_ready), 32'd0);
    idleCycles(1);
    checkOutput("ld_ready2", 32'(in_ready), 32'd0);
    applyStimulus(0, 0, 16'h0, 16'h0, 16'h0, 0, 3'd0, 0, 0, 0, 1, 16'hBEEF);
    checkOutput("ld_wr_en", 32'(reg_wr_en), 32'd1);
    checkOutput("ld_addr", 32'(reg_wr_addr), 32'd2);
    checkOutput("ld_data", 32'(reg_data), 32'hBEEF);
    checkOutput("ld_stall", 32'(stall_cnt), 32'd3);
    checkOutput("ld_ready_back", 32'(in_ready), 32'd1);
    idleCycles(1);
    checkOutput("ld_wr_once", 32'(reg_wr_en), 32'd0);

    // Flush beats a simultaneous mem_done
    applyStimulus(1, 1, 16'h0, 16'h0, 16'h0, 1, 3'd6, 1, 0, 0, 0, 16'h0);
    applyStimulus(0, 0, 16'h0, 16'h0, 16'h0, 0, 3'd0, 0, 0, 1, 1, 16'h1234);
    checkOutput("fl_wr_en", 32'(reg_wr_en), 32'd0);
    checkOutput("fl_ready", 32'(in_ready), 32'd1);
    checkOutput("fl_stall", 32'(stall_cnt), 32'd4);
    idleCycles(1);

    // Stall counter saturates
    doReset();
    applyStimulus(1, 1, 16'h0, 16'h0, 16'h0, 1, 3'd1, 1, 0, 0, 0, 16'h0);
    idleCycles(300);
    checkOutput("sat_stall", 32'(stall_cnt), 32'd255);
    applyStimulus(0, 0, 16'h0, 16'h0, 16'h0, 0, 3'd0, 0, 0, 1, 0, 16'h0);
    checkOutput("sat_hold", 32'(stall_cnt), 32'd255);
    checkOutput("sat_ready", 32'(in_ready), 32'd1);

    // Halt is sticky and ignores further instructions until reset
    applyStimulus(1, 0, 16'h0077, 16'h0, 16'h0, 1, 3'd1, 0, 1, 0, 0, 16'h0);
    checkOutput("halt_wr_en", 32'(reg_wr_en), 32'd0);
    checkOutput("halt_flag", 32'(halted), 32'd1);
    checkOutput("halt_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 16'h0099, 16'h0, 16'h0, 1, 3'd3, 0, 0, 0, 0, 16'h0);
      checkOutput("halt_ignore_wr", 32'(reg_wr_en), 32'd0);
      checkOutput("halt_sticky", 32'(halted), 32'd1);
    end
    doReset();
    checkOutput("halt_cleared", 32'(halted), 32'd0);
    checkOutput("halt_ready_back", 32'(in_ready), 32'd1);

    // Random traffic, with occasional resets (more often once halted)
    for (int i = 0; i < 3000; i++) begin
      rst = mHalted ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) == 0);
      applyStimulus($urandom_range(0, 99) < 70, 2'($urandom_range(0, 3)),
                    16'($urandom), 16'($urandom), 16'($urandom),
                    $urandom_range(0, 99) < 80, 3'($urandom_range(0, 7)),
                    $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 2,
                    $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 40,
                    16'($urandom));
    end
    rst = 1'b0;
    idleCycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage_n.md
Name: wb_stage_n

Overview:
- Parametrised write-back stage: a MEM/WB pipeline register plus a 4-source write-back select (ALU result, memory data, PC+2, immediate).
- Supports multi-cycle loads: a load is held until the memory signals completion.
- Provides flush, sticky halt and a saturating stall counter.
- Sits between the memory stage and the register file write port in decode.

Parameters:
DATA_W, 16, datapath width of all data inputs and reg_data
REG_AW, 3, register-file address width
CNT_W, 8, stall counter width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  memory stage presents an instruction
in_ready  output  1  stage can accept this cycle
alu_out  input  DATA_W  result from execute
pc_plus2  input  DATA_W  PC+2 from fetch, for link
imm  input  DATA_W  immediate, for load-immediate
wb_sel  input  2  source select: 0 ALU, 1 MEM, 2 PC+2, 3 IMM
reg_wr_in  input  1  instruction writes a register
dst_in  input  REG_AW  destination register
is_load  input  1  instruction needs mem_data
halt_in  input  1  instruction is HALT
flush  input  1  kill the pending/incoming instruction
mem_done  input  1  mem_data valid this cycle
mem_data  input  DATA_W  memory read data
reg_wr_en  output  1  register file write strobe (one cycle per instruction)
reg_wr_addr  output  REG_AW  write address
reg_data  output  DATA_W  write data
halted  output  1  sticky halt indication
stall_cnt  output  CNT_W  cycles spent in WAIT_MEM, saturating
fwd_valid  output  1  bypass valid (WB_FWD_EN only)
fwd_addr  output  REG_AW  bypass register (WB_FWD_EN only)
fwd_data  output  DATA_W  bypass value (WB_FWD_EN only)

Behaviour:
- Single clock domain; rst is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: state = IDLE, reg_wr_en = 0, reg_wr_addr = 0, reg_data = 0, halted = 0, stall_cnt = 0, all fwd_* outputs = 0.
- FSM states: IDLE, WAIT_MEM, HALT.
- in_ready = (state == IDLE). It is combinational from state only, never from in_valid.
- Accept condition: in_valid && in_ready.
- Outputs are registered. Latency: write strobe appears the cycle after accept (non-load) or the cycle after mem_done (load).
- reg_wr_en defaults to 0 every cycle. It pulses high for exactly one cycle per committed writing instruction.
- IDLE, accept, flush = 1: instruction dropped, no write, stay IDLE.
- IDLE, accept, halt_in = 1: go to HALT, halted <= 1, no write regardless of reg_wr_in.
- IDLE, accept, is_load = 1, mem_done = 0: latch wb_sel, reg_wr_in, dst_in, pc_plus2, imm, alu_out; go to WAIT_MEM.
- IDLE, accept, otherwise (non-load, or load with mem_done = 1):
  - reg_wr_en <= reg_wr_in
  - reg_wr_addr <= dst_in
  - reg_data <= source selected by wb_sel; MEM selects mem_data.
- WAIT_MEM:
  - stall_cnt increments each cycle, saturating at all-ones (no wrap).
  - mem_done = 1: commit using the latched fields and the live mem_data, return to IDLE.
  - flush = 1: discard with no write and return to IDLE. Flush wins over a simultaneous mem_done.
- HALT: absorbing; in_ready = 0; no writes. Only rst exits it.
- wb_sel = 1 with is_load = 0 is legal: mem_data is sampled on the accept cycle.
- rst in the middle of WAIT_MEM: the pending instruction is discarded, no write occurs, stall_cnt is cleared.
- Select mux is full-width DATA_W; no sign or zero extension happens in this block.

Optional Feature:
Macro WB_FWD_EN.
- Defined:
  - fwd_valid = reg_wr_en, fwd_addr = reg_wr_addr, fwd_data = reg_data, giving the decode/execute bypass the value being written this cycle.
  - Additionally, while in WAIT_MEM, fwd_valid = 0 (the data is not yet known).
- Undefined: fwd_valid, fwd_addr and fwd_data are tied to 0. The ports stay present so the port list is identical in both builds.

Test Plan:
- Reset, then ALU op: wb_sel = 0, alu_out = 0x1234, dst_in = 5, reg_wr_in = 1 -> next cycle reg_wr_en = 1, addr = 5, data = 0x1234; the cycle after, reg_wr_en = 0.
- Link: wb_sel = 2, pc_plus2 = 0x0042, dst_in = 7 -> next cycle writes R7 = 0x0042. With wb_sel = 3 and imm = 0xFFEE -> data = 0xFFEE.
- Multi-cycle load: is_load = 1, wb_sel = 1, dst_in = 2, mem_done low for 3 cycles, then mem_data = 0xBEEF with mem_done = 1 ->
  - in_ready = 0 for 3 cycles
  - stall_cnt = 3
  - next cycle R2 = 0xBEEF written once.
- Flush during WAIT_MEM asserted in the same cycle as mem_done -> no reg_wr_en pulse, in_ready = 1 the next cycle. Separately, stall 300 cycles with CNT_W = 8 -> stall_cnt = 255.
- HALT with reg_wr_in = 1 -> no write, halted = 1 and in_ready = 0 persist. Further in_valid is ignored. rst clears halted to 0.
- WB_FWD_EN build, ALU write to R3 = 0x00AA -> fwd_valid = 1, fwd_addr = 3, fwd_data = 0x00AA in the same cycle as reg_wr_en. During WAIT_MEM, fwd_valid = 0. Without the macro, fwd_* are always 0.
